// File: rtl/systolic_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_seq_controller
//  Purpose  : Load/wait/rolling sequencer for the TPU systolic array, with
//             stall, busy/done handshake and optional abort (SYSTOLIC_ABORT_EN).
//  Revision : 1.0  initial release
// ============================================================================
module systolic_seq_controller #(
    parameter int ARRAY_SIZE = 32,
    parameter int OUT_ROWS   = 64,
    parameter int MAX_SETS   = 4,
    parameter int ADDR_DEPTH = 128,
    parameter int CYC_W      = 9,
    parameter int ADDR_W     = $clog2(ADDR_DEPTH),
    parameter int IDX_W      = $clog2(OUT_ROWS),
    parameter int SET_W      = $clog2(MAX_SETS)
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              tpu_start,
    input  logic [SET_W-1:0]  num_sets,
    input  logic              stall,
`ifdef SYSTOLIC_ABORT_EN
    input  logic              tpu_abort,
`endif
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] addr_serial_num,
    output logic              alu_start,
    output logic [CYC_W-1:0]  cycle_num,
    output logic [IDX_W-1:0]  matrix_index,
    output logic [SET_W-1:0]  data_set,
    output logic              tpu_busy,
    output logic              tpu_done
);

    localparam logic [CYC_W-1:0]  c_wb_start = CYC_W'(ARRAY_SIZE + 1);
    localparam logic [CYC_W-1:0]  c_cyc_max  = {CYC_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_addr_max = ADDR_W'(ADDR_DEPTH - 1);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(OUT_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_DATA = 2'd1,
        WAIT1     = 2'd2,
        ROLLING   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [CYC_W-1:0]  cycle_q,    cycle_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [SET_W-1:0]  set_q,      set_d;
    logic [SET_W-1:0]  num_sets_q, num_sets_d;
    logic              done_q,     done_d;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        cycle_d           = cycle_q;
        idx_d             = idx_q;
        set_d             = set_q;
        num_sets_d        = num_sets_q;
        done_d            = 1'b0;
        alu_start         = 1'b0;
        sram_write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (tpu_start) begin
                    state_d    = LOAD_DATA;
                    addr_d     = '0;
                    num_sets_d = num_sets;
                    cycle_d    = '0;
                    idx_d      = '0;
                    set_d      = '0;
                end
            end
            LOAD_DATA: begin
                addr_d  = ADDR_W'(1);
                state_d = WAIT1;
            end
            WAIT1: begin
                addr_d  = ADDR_W'(2);
                cycle_d = '0;
                idx_d   = '0;
                set_d   = '0;
                state_d = ROLLING;
            end
            ROLLING: begin
                if (!stall) begin
                    alu_start = 1'b1;
                    cycle_d   = (cycle_q == c_cyc_max) ? cycle_q : cycle_q + CYC_W'(1);
                    addr_d    = (addr_q == c_addr_max) ? addr_q : addr_q + ADDR_W'(1);
                    if (cycle_q >= c_wb_start) begin
                        sram_write_enable = 1'b1;
                        if (idx_q == c_idx_last) begin
                            idx_d = '0;
                            set_d = set_q + SET_W'(1);
                            // Last row of the last set: counters return to 0 for IDLE.
                            if (set_q == num_sets_q) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                cycle_d = '0;
                                set_d   = '0;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SYSTOLIC_ABORT_EN
        // Abort overrides stall and termination; the address is left as is.
        if (tpu_abort && (state_q != IDLE)) begin
            state_d           = IDLE;
            cycle_d           = '0;
            idx_d             = '0;
            set_d             = '0;
            done_d            = 1'b0;
            alu_start         = 1'b0;
            sram_write_enable = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cycle_q    <= '0;
            idx_q      <= '0;
            set_q      <= '0;
            num_sets_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cycle_q    <= cycle_d;
            idx_q      <= idx_d;
            set_q      <= set_d;
            num_sets_q <= num_sets_d;
            done_q     <= done_d;
        end
    end

    assign addr_serial_num = addr_q;
    assign cycle_num       = cycle_q;
    assign matrix_index    = idx_q;
    assign data_set        = set_q;
    assign tpu_done        = done_q;
    assign tpu_busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_seq_controller
//  Purpose  : Directed, table-driven check of systolic_seq_controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_seq_controller;

    localparam int c_AS   = 4;
    localparam int c_ROWS = 8;
    localparam int c_SETS = 4;
    localparam int c_DEP  = 16;
    localparam int c_CYCW = 6;

    logic       clk = 1'b0;
    logic       srstn;
    logic       tpu_start;
    logic [1:0] num_sets;
    logic       stall;
`ifdef SYSTOLIC_ABORT_EN
    logic       tpu_abort;
`endif
    logic       sram_write_enable;
    logic [3:0] addr_serial_num;
    logic       alu_start;
    logic [5:0] cycle_num;
    logic [2:0] matrix_index;
    logic [1:0] data_set;
    logic       tpu_busy;
    logic       tpu_done;

    systolic_seq_controller #(
        .ARRAY_SIZE (c_AS),
        .OUT_ROWS   (c_ROWS),
        .MAX_SETS   (c_SETS),
        .ADDR_DEPTH (c_DEP),
        .CYC_W      (c_CYCW)
    ) dut (
        .clk               (clk),
        .srstn             (srstn),
        .tpu_start         (tpu_start),
        .num_sets          (num_sets),
        .stall             (stall),
`ifdef SYSTOLIC_ABORT_EN
        .tpu_abort         (tpu_abort),
`endif
        .sram_write_enable (sram_write_enable),
        .addr_serial_num   (addr_serial_num),
        .alu_start         (alu_start),
        .cycle_num         (cycle_num),
        .matrix_index      (matrix_index),
        .data_set          (data_set),
        .tpu_busy          (tpu_busy),
        .tpu_done          (tpu_done)
    );

    always #5 clk = ~clk;

    // exp layout: {we, alu, busy, done, addr[3:0], cyc[5:0], idx[2:0], set[1:0]}
    typedef struct {
        logic        start;
        logic [1:0]  nsets;
        logic        stall;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic       m_done;
    logic [3:0] m_addr;

    function automatic logic [18:0] pack(input logic we, input logic alu, input logic busy,
                                         input logic done, input logic [3:0] addr,
                                         input logic [5:0] cyc, input logic [2:0] idx,
                                         input logic [1:0] set);
        return {we, alu, busy, done, addr, cyc, idx, set};
    endfunction

    function automatic logic [18:0] actual();
        return pack(sram_write_enable, alu_start, tpu_busy, tpu_done,
                    addr_serial_num, cycle_num, matrix_index, data_set);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [18:0] act,
                         input logic [18:0] exp, input logic [18:0] mask);
        n_vec++;
        if ((act & mask) !== (exp & mask)) begin
            n_miss++;
            $display("FAIL %s: got {we,alu,busy,done,addr,cyc,idx,set}=%b_%b_%b_%b_%0d_%0d_%0d_%0d expected %b_%b_%b_%b_%0d_%0d_%0d_%0d (mask %h)",
                     name, act[18], act[17], act[16], act[15], act[14:11], act[10:5], act[4:2], act[1:0],
                     exp[18], exp[17], exp[16], exp[15], exp[14:11], exp[10:5], exp[4:2], exp[1:0], mask);
        end
    endtask

    // One run from its accepted start up to (not including) its done cycle.
    task automatic add_run(input int ns, input int st_at, input int st_len,
                           input int xs_at, input int st2);
        int   p = 0;
        int   n_wr = (ns + 1) * c_ROWS;
        vec_t v;
        for (int t = 0; t < 1000; t++) begin
            v.start = (t == 0) || (t == xs_at);
            v.nsets = (t == 0) ? 2'(ns) : 2'(ns ^ 2);
            v.stall = ((t >= st_at) && (t < st_at + st_len)) || (t == st2);
            if (t == 0) begin
                v.exp  = pack(0, 0, 0, m_done, m_addr, 0, 0, 0);
                m_done = 1'b0;
                vecs.push_back(v);
            end else if (t == 1) begin
                v.exp = pack(0, 0, 1, 0, 4'd0, 0, 0, 0);
                vecs.push_back(v);
            end else if (t == 2) begin
                v.exp = pack(0, 0, 1, 0, 4'd1, 0, 0, 0);
                vecs.push_back(v);
            end else begin
                logic we;
                we    = !v.stall && (p >= c_AS + 1);
                v.exp = pack(we, !v.stall, 1, 0, 4'(imin(2 + p, c_DEP - 1)), 6'(p),
                             (p >= c_AS + 1) ? 3'((p - c_AS - 1) % c_ROWS) : 3'd0,
                             (p >= c_AS + 1) ? 2'((p - c_AS - 1) / c_ROWS) : 2'd0);
                vecs.push_back(v);
                if (!v.stall) begin
                    if (we && (p - c_AS - 1 == n_wr - 1)) begin
                        m_done = 1'b1;
                        m_addr = 4'(imin(3 + p, c_DEP - 1));
                        return;
                    end
                    p++;
                end
            end
        end
    endtask

    task automatic add_idle(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.start = 1'b0;
            v.nsets = 2'd0;
            v.stall = 1'b0;
            v.exp   = pack(0, 0, 0, m_done, m_addr, 0, 0, 0);
            m_done  = 1'b0;
            vecs.push_back(v);
        end
    endtask

    task automatic apply_vectors(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            tpu_start = vecs[i].start;
            num_sets  = vecs[i].nsets;
            stall     = vecs[i].stall;
            #1;
            check($sformatf("%s[%0d]", tag, i), actual(), vecs[i].exp, '1);
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srstn     = 1'b0;
        tpu_start = 1'b0;
        num_sets  = 2'd0;
        stall     = 1'b0;
`ifdef SYSTOLIC_ABORT_EN
        tpu_abort = 1'b0;
`endif
        m_done = 1'b0;
        m_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", actual(), '0, '1);
        @(negedge clk);
        srstn = 1'b1;

        // Basic run with an ignored start at T5; stall run starting in the
        // previous done cycle; max-sets run with address saturation.
        add_run(1, -1, 0, 5, -1);
        add_run(1, 10, 3, -1, 2);
        add_run(3, -1, 0, -1, -1);
        add_idle(2);
        apply_vectors("runs");

        // Asynchronous reset in the middle of the write phase.
        @(negedge clk);
        tpu_start = 1'b1;
        num_sets  = 2'd1;
        stall     = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tpu_start = 1'b0;
        end
        #1 check("pre_reset_write", actual(), pack(1, 1, 1, 0, 4'd11, 6'd9, 3'd4, 2'd0), '1);
        srstn = 1'b0;
        #1 check("async_reset", actual(), '0, '1);
        @(posedge clk);
        #1 check("reset_hold", actual(), '0, '1);
        @(negedge clk);
        srstn = 1'b1;
        #1 check("reset_release", actual(), '0, '1);
        m_addr = 4'd0;
        m_done = 1'b0;
        add_run(1, -1, 0, -1, -1);
        add_idle(2);
        apply_vectors("after_reset");

`ifdef SYSTOLIC_ABORT_EN
        @(negedge clk);
        tpu_start = 1'b1;
        num_sets  = 2'd1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            tpu_start = 1'b0;
            tpu_abort = (k == 15);
            #1;
            if (k == 14)
                check("abort_pre", actual(), pack(1, 1, 1, 0, 4'd13, 6'd11, 3'd6, 2'd0), '1);
        end
        check("abort_cycle", actual(), pack(0, 0, 1, 0, 4'd0, 6'd12, 3'd7, 2'd0),
              19'b111_1_0000_111111_111_11);
        for (int k = 16; k <= 19; k++) begin
            @(negedge clk);
            tpu_abort = 1'b0;
            #1 check($sformatf("abort_after[%0d]", k), actual(), pack(0, 0, 0, 0, 4'd0, 0, 0, 0),
                     19'b111_1_0000_111111_111_11);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_seq_controller.md
Name: systolic_seq_controller

Overview:
Parametrised next-generation controller for the systolic array in the TPU datapath.
- Sequences load, wait and rolling computation.
- Generates input address serial numbers and the ALU enable.
- Counts cycles and steps the result row index and data-set index for SRAM write-back.
- Additions: runtime-programmable data-set count, a stall input that freezes the pipeline, and a busy/done handshake. The rest of the TPU uses it as a drop-in sequencer.

Parameters:
- ARRAY_SIZE, 32: systolic array dimension; write-back begins once cycle_num reaches ARRAY_SIZE+1.
- OUT_ROWS, 64: result rows written per data set; power of 2, at least 2.
- MAX_SETS, 4: maximum data sets per run; power of 2, at least 2.
- ADDR_DEPTH, 128: input address range; power of 2.
- CYC_W, 9: cycle counter width; must satisfy 2^CYC_W-1 > ARRAY_SIZE+1.
- Derived widths: ADDR_W=clog2(ADDR_DEPTH), IDX_W=clog2(OUT_ROWS), SET_W=clog2(MAX_SETS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- srstn  in  1  reset, asynchronous, active-low.
- tpu_start  in  1  start request; sampled only in IDLE.
- num_sets  in  SET_W  number of data sets minus 1; captured into num_sets_q on accepted start.
- stall  in  1  freezes ROLLING progress while high.
- sram_write_enable  out  1  result write strobe; combinational.
- addr_serial_num  out  ADDR_W  input-data address selector; registered.
- alu_start  out  1  shift/multiply enable to the array; combinational.
- cycle_num  out  CYC_W  rolling-phase cycle counter; registered.
- matrix_index  out  IDX_W  result row index for SRAM write; registered.
- data_set  out  SET_W  current data set; registered.
- tpu_busy  out  1  high in any state other than IDLE; combinational from state.
- tpu_done  out  1  one-cycle completion pulse; registered.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state=IDLE; addr_serial_num, cycle_num, matrix_index, data_set and num_sets_q all 0; tpu_done=0.
  - No write strobe in the cycle after reset releases.
- State machine: IDLE -> LOAD_DATA -> WAIT1 -> ROLLING -> IDLE.
- IDLE:
  - tpu_start=1 moves to LOAD_DATA, sets addr_serial_num to 0 and captures num_sets.
  - Otherwise all registered outputs hold (addr_serial_num keeps its last value).
  - cycle_num, matrix_index and data_set read 0 in IDLE after any run.
- LOAD_DATA: addr_serial_num_next=1; go to WAIT1.
- WAIT1: addr_serial_num_next=2; go to ROLLING. cycle_num, matrix_index and data_set are 0 on entry to ROLLING.
- tpu_start is ignored in LOAD_DATA, WAIT1 and ROLLING, and is not queued.
- stall is ignored outside ROLLING.
- ROLLING with stall=1:
  - All registers hold.
  - alu_start=0, sram_write_enable=0.
- ROLLING with stall=0:
  - alu_start=1.
  - cycle_num increments, saturating at 2^CYC_W-1.
  - addr_serial_num increments, saturating at ADDR_DEPTH-1.
- Write phase: active while cycle_num >= ARRAY_SIZE+1, stall=0 and state is ROLLING.
  - sram_write_enable=1.
  - If matrix_index < OUT_ROWS-1, matrix_index increments.
  - If matrix_index = OUT_ROWS-1, matrix_index wraps to 0 and data_set increments.
  - Before the write phase, matrix_index is forced to 0 and data_set holds.
- Termination:
  - The write with matrix_index=OUT_ROWS-1 and data_set=num_sets_q goes to IDLE on the next edge, with tpu_done=1.
  - tpu_done returns to 0 one cycle later.
  - A run performs exactly (num_sets_q+1)*OUT_ROWS writes.
  - If num_sets_q = MAX_SETS-1, data_set wraps to 0 at the end; no extra write occurs.
- Latency:
  - tpu_start accepted at edge 0 gives the first alu_start at cycle 3.
  - First write at cycle 3+ARRAY_SIZE+1, plus one cycle per stalled ROLLING cycle.
  - A start in the same cycle that tpu_done is high is accepted, because the state is IDLE.

Optional Feature:
SYSTOLIC_ABORT_EN
- With the macro: adds port tpu_abort (in, 1).
  - tpu_abort=1 in LOAD_DATA, WAIT1 or ROLLING forces IDLE on the next edge.
  - Clears cycle_num, matrix_index and data_set.
  - tpu_done stays 0; alu_start and sram_write_enable are 0 in the abort cycle.
  - Abort has priority over stall and termination. It is ignored in IDLE.
- Without the macro: the port is absent and behaviour is exactly as above.

Test Plan:
All scenarios use ARRAY_SIZE=4, OUT_ROWS=8, MAX_SETS=4, ADDR_DEPTH=16, CYC_W=6.
- Basic run: num_sets=1 and tpu_start pulse at T0 -> alu_start from T3; 16 sram_write_enable pulses at T8..T23; matrix_index 0..7 twice; data_set 0 then 1; state IDLE and tpu_done=1 at T24 only; tpu_busy high T1..T23.
- Stall: as the basic run plus stall=1 at T10..T12 -> strobes and counters frozen for 3 cycles, alu_start=0 at T10..T12, tpu_done at T27, still 16 writes.
- Address saturation and max sets: num_sets=3 -> addr_serial_num 0,1,2,...,15 then stays 15; 32 writes; data_set reaches 3; tpu_done at T40.
- Start while busy: second tpu_start at T5 -> ignored, num_sets_q unchanged. Start at T24, the tpu_done cycle -> accepted, LOAD_DATA at T25.
- Async reset: srstn low at T12 mid-write -> outputs immediately 0, state IDLE, no tpu_done. After release, a new start runs the full basic sequence.
- SYSTOLIC_ABORT_EN: tpu_abort at T15 -> IDLE at T16, counters 0, no tpu_done, no further writes.
